// File: rtl/expand_n_shift.sv
// Streaming widener: sign-extends narrow samples, applies a per-sample left shift, and saturates to Win bits.
// Optional saturation event counter is compiled in with `define EXPAND_SAT_CNT_EN.
module expand_n_shift #(
   parameter int Win    = 16,
   parameter int Nround = 3,
   parameter int Nsat   = 4,
   parameter int SHW    = 4,
   parameter int CNTW   = 16,
   localparam int Wn    = Win - Nsat - Nround
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [Wn-1:0]   din,
   input  logic [SHW-1:0]  shift,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [Win-1:0]  dout,
   output logic            sat_flag,
   input  logic            sat_clr,
   output logic [CNTW-1:0] sat_cnt
);

   // Wide enough that the largest shift never loses a bit before the range check.
   localparam int WEXT = Win + 2**SHW - 1;
   localparam logic [Win-1:0] POS_FS = {1'b0, {(Win-1){1'b1}}};
   localparam logic [Win-1:0] NEG_FS = {1'b1, {(Win-1){1'b0}}};

   logic [WEXT-1:0] ext;
   logic [WEXT-1:0] prod;
   logic            ovf;
   logic            adv;

   logic            s1_valid_q, s1_valid_d;
   logic [Win-1:0]  s1_data_q,  s1_data_d;
   logic            s1_ovf_q,   s1_ovf_d;
   logic            s1_neg_q,   s1_neg_d;

   logic            out_valid_q, out_valid_d;
   logic [Win-1:0]  dout_q,      dout_d;
   logic            sat_flag_q,  sat_flag_d;

   assign ext  = {{(WEXT-Wn){din[Wn-1]}}, din};
   assign prod = ext << shift;
   // In range only when every bit from the result sign bit upward agrees.
   assign ovf  = (|prod[WEXT-1:Win-1]) & ~(&prod[WEXT-1:Win-1]);

   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_ovf_d    = s1_ovf_q;
      s1_neg_d    = s1_neg_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      sat_flag_d  = sat_flag_q;
      if (adv) begin
         s1_valid_d  = in_valid;
         s1_data_d   = prod[Win-1:0];
         s1_ovf_d    = ovf;
         s1_neg_d    = din[Wn-1];
         out_valid_d = s1_valid_q;
         sat_flag_d  = s1_valid_q & s1_ovf_q;
         if (s1_ovf_q) dout_d = s1_neg_q ? NEG_FS : POS_FS;
         else          dout_d = s1_data_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_ovf_q    <= 1'b0;
         s1_neg_q    <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         sat_flag_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_ovf_q    <= s1_ovf_d;
         s1_neg_q    <= s1_neg_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         sat_flag_q  <= sat_flag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign sat_flag  = sat_flag_q;

`ifdef EXPAND_SAT_CNT_EN
   logic [CNTW-1:0] sat_cnt_q, sat_cnt_d;

   // Clear takes priority over a same-cycle saturated beat; count sticks at all-ones.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_clr)
         sat_cnt_d = '0;
      else if (out_valid_q & out_ready & sat_flag_q & ~(&sat_cnt_q))
         sat_cnt_d = sat_cnt_q + CNTW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sat_cnt_q <= '0;
      else         sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`else
   logic unused_sat_clr;
   assign unused_sat_clr = sat_clr;
   assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_expand_n_shift.sv
// Self-checking bench for expand_n_shift: vector table, scoreboard queue, and handshake/reset corner sequences.
module tb_expand_n_shift;

   localparam int CNTW = 8;
`ifdef EXPAND_SAT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [8:0]      din = '0;
   logic [3:0]      shift = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [15:0]     dout;
   logic            sat_flag;
   logic            sat_clr = 1'b0;
   logic [CNTW-1:0] sat_cnt;

   expand_n_shift #(.CNTW(CNTW)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .sat_flag(sat_flag), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] dout;
      logic        sat;
   } exp_t;

   typedef struct packed {
      logic [8:0]  din;
      logic [3:0]  sh;
      logic [15:0] dout;
      logic        sat;
   } vec_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   int   nbeats = 0;
   bit   toggle_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   function automatic exp_t model(input logic [8:0] d, input logic [3:0] s);
      exp_t   e;
      longint v;
      v = longint'($signed(d)) * (longint'(1) << s);
      if (v > 32767)       begin e.dout = 16'h7FFF; e.sat = 1'b1; end
      else if (v < -32768) begin e.dout = 16'h8000; e.sat = 1'b1; end
      else                 begin e.dout = v[15:0];  e.sat = 1'b0; end
      return e;
   endfunction

   // Presents one sample; pushes its expectation on the accepting cycle.
   task automatic send(input logic [8:0] d, input logic [3:0] s, input exp_t e);
      bit ok = 1'b0;
      in_valid = 1'b1; din = d; shift = s;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin q.push_back(e); ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #2;
         if (q.size() == 0) begin ok = 1'b1; break; end
      end
      chk("drain_empty", {31'd0, ok}, 32'd1);
   endtask

   // Output monitor: pops the scoreboard on every beat and checks stall stability.
   logic        prev_stall = 1'b0;
   logic [15:0] prev_dout  = '0;
   always @(negedge clk) begin
      if (!resetn) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && out_valid) chk("stall_stable", {16'd0, dout}, {16'd0, prev_dout});
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               nbeats++;
               $display("beat %0d: dout=%h sat=%0b (expected %h/%0b)", nbeats, dout, sat_flag, e.dout, e.sat);
               chk("dout", {16'd0, dout}, {16'd0, e.dout});
               chk("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
            end
         end
         prev_stall <= out_valid & ~out_ready;
         prev_dout  <= dout;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[12];
      exp_t e;
      int   b0;
      logic [8:0] d;

      vecs[0]  = '{din: 9'h0FF, sh: 4'd3,  dout: 16'h07F8, sat: 1'b0};
      vecs[1]  = '{din: 9'h0FF, sh: 4'd8,  dout: 16'h7FFF, sat: 1'b1};
      vecs[2]  = '{din: 9'h001, sh: 4'd15, dout: 16'h7FFF, sat: 1'b1};
      vecs[3]  = '{din: 9'h1FF, sh: 4'd15, dout: 16'h8000, sat: 1'b0};
      vecs[4]  = '{din: 9'h100, sh: 4'd8,  dout: 16'h8000, sat: 1'b1};
      vecs[5]  = '{din: 9'h1FF, sh: 4'd0,  dout: 16'hFFFF, sat: 1'b0};
      vecs[6]  = '{din: 9'h100, sh: 4'd0,  dout: 16'hFF00, sat: 1'b0};
      vecs[7]  = '{din: 9'h0FF, sh: 4'd0,  dout: 16'h00FF, sat: 1'b0};
      vecs[8]  = '{din: 9'h0FF, sh: 4'd7,  dout: 16'h7F80, sat: 1'b0};
      vecs[9]  = '{din: 9'h001, sh: 4'd14, dout: 16'h4000, sat: 1'b0};
      vecs[10] = '{din: 9'h100, sh: 4'd7,  dout: 16'h8000, sat: 1'b0};
      vecs[11] = '{din: 9'h101, sh: 4'd8,  dout: 16'h8000, sat: 1'b1};

      // Reset state
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_dout", {16'd0, dout}, 32'd0);
      chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
      chk("rst_sat_cnt", {24'd0, sat_cnt}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // First-sample latency: nothing after the accepting edge, result after the next one
      send(9'h0FF, 4'd3, exp_t'({16'h07F8, 1'b0}));
      chk("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_edge2_dout", {16'd0, dout}, 32'h07F8);
      drain();

      // Vector table, back-to-back with out_ready=1 (four saturating entries)
      for (int i = 0; i < 12; i++)
         send(vecs[i].din, vecs[i].sh, exp_t'({vecs[i].dout, vecs[i].sat}));
      drain();
      chk("sat_cnt_after_table", {24'd0, sat_cnt}, CNT_EN ? 32'd4 : 32'd0);

      // Ramp stream with out_ready toggling
      b0 = nbeats;
      toggle_en = 1'b1;
      fork
         while (toggle_en) begin
            @(posedge clk); #1;
            if (toggle_en) out_ready = ~out_ready;
         end
      join_none
      for (int i = 0; i < 8; i++) begin
         d = 9'(i * 37 - 130);
         send(d, 4'(i + 1), model(d, 4'(i + 1)));
      end
      drain();
      toggle_en = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      chk("ramp_beats", nbeats - b0, 32'd8);

      // Clear wins over a simultaneous saturated beat
      send(9'h0FF, 4'd15, exp_t'({16'h7FFF, 1'b1}));
      @(posedge clk); #1;
      chk("clr_beat_valid", {31'd0, out_valid & sat_flag}, 32'd1);
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      chk("sat_cnt_clear_wins", {24'd0, sat_cnt}, 32'd0);
      send(9'h180, 4'd12, exp_t'({16'h8000, 1'b1}));
      drain();
      chk("sat_cnt_after_clear", {24'd0, sat_cnt}, CNT_EN ? 32'd1 : 32'd0);

      // Push the counter past its maximum
      for (int i = 0; i < 2**CNTW + 4; i++)
         send(9'h0F0, 4'd10, exp_t'({16'h7FFF, 1'b1}));
      drain();
      chk("sat_cnt_sticks", {24'd0, sat_cnt}, CNT_EN ? 32'(2**CNTW - 1) : 32'd0);

      // Asynchronous reset with two samples in flight
      send(9'h010, 4'd2, model(9'h010, 4'd2));
      send(9'h020, 4'd2, model(9'h020, 4'd2));
      #2;
      resetn = 1'b0;
      #1;
      chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("areset_dout", {16'd0, dout}, 32'd0);
      chk("areset_sat_flag", {31'd0, sat_flag}, 32'd0);
      chk("areset_sat_cnt", {24'd0, sat_cnt}, 32'd0);
      q.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
      send(9'h1F0, 4'd4, exp_t'({16'hFF00, 1'b0}));
      chk("post_lat_edge1", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("post_lat_edge2", {31'd0, out_valid}, 32'd1);
      chk("post_lat_dout", {16'd0, dout}, 32'hFF00);
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
